// File: rtl/dm_cache.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache
// Brief    : Direct-mapped, write-through, no-write-allocate one-word-line
//            cache. Read hits complete in the request cycle. Read misses are
//            filled from slow memory after a fixed wait count. Hit and miss
//            statistics saturate at 0xFFFF.
// Revision : 1.0 - initial release
// ============================================================================
module dm_cache #(
  parameter int LINES   = 16,
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 32 - IDX - 2;
  localparam int LATW = $clog2(MEM_LAT + 1);

  localparam logic [LATW-1:0] LAT_ONE  = LATW'(1);
  localparam logic [LATW-1:0] LAT_LAST = LATW'(MEM_LAT);
  localparam logic [15:0]     CNT_MAX  = 16'hFFFF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e            state_q,     state_d;
  logic [LATW-1:0]   lat_cnt_q,   lat_cnt_d;
  logic [31:0]       fill_addr_q, fill_addr_d;
  logic [LINES-1:0]  valid_q;
  logic [TAGW-1:0]   tag_q  [LINES];
  logic [31:0]       data_q [LINES];
  logic [15:0]       hit_cnt_q;
  logic [15:0]       miss_cnt_q;

  logic [IDX-1:0]    cpu_idx;
  logic [TAGW-1:0]   cpu_tag;
  logic [IDX-1:0]    fill_idx;
  logic [TAGW-1:0]   fill_tag;
  logic              hit;

  logic              hit_inc;
  logic              miss_inc;
  logic              line_fill;
  logic              line_wr;

  // Address split for the live request and for the latched fill address
  assign cpu_idx  = cpu_addr[IDX+1:2];
  assign cpu_tag  = cpu_addr[31:IDX+2];
  assign fill_idx = fill_addr_q[IDX+1:2];
  assign fill_tag = fill_addr_q[31:IDX+2];

  // Combinational lookup of the indexed line
  assign hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Next-state and output decode; everything is held low while reset is asserted
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    fill_addr_d = fill_addr_q;
    cpu_ready   = 1'b0;
    cpu_rdata   = 32'h0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    line_fill   = 1'b0;
    line_wr     = 1'b0;

    if (reset) begin
      case (state_q)
        S_IDLE: begin
          if (cpu_write) begin
            // Write-through: forward immediately, update the line only on a hit
            mem_write = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_ready = 1'b1;
            line_wr   = hit;
          end else if (cpu_read) begin
            if (hit) begin
              cpu_ready = 1'b1;
              cpu_rdata = data_q[cpu_idx];
              hit_inc   = 1'b1;
            end else begin
              fill_addr_d = cpu_addr;
              lat_cnt_d   = LAT_ONE;
              state_d     = S_FILL;
            end
          end
        end

        S_FILL: begin
          // Memory read is held for the whole wait window; data is taken on the last cycle
          mem_read = 1'b1;
          mem_addr = fill_addr_q;
          if (lat_cnt_q == LAT_LAST) begin
            cpu_ready = 1'b1;
            cpu_rdata = mem_rdata;
            line_fill = 1'b1;
            miss_inc  = 1'b1;
            lat_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            lat_cnt_d = lat_cnt_q + LAT_ONE;
          end
        end
      endcase
    end
  end

  // Control state, valid bits and statistics with asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      fill_addr_q <= 32'h0;
      valid_q     <= '0;
      hit_cnt_q   <= 16'h0;
      miss_cnt_q  <= 16'h0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      fill_addr_q <= fill_addr_d;
      if (line_fill) begin
        valid_q[fill_idx] <= 1'b1;
      end
      if (hit_inc && (hit_cnt_q != CNT_MAX)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (miss_inc && (miss_cnt_q != CNT_MAX)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  // Tag and data storage is not reset; validity alone guards its contents
  always_ff @(posedge clk) begin
    if (line_fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_rdata;
    end else if (line_wr) begin
      data_q[cpu_idx]  <= cpu_wdata;
    end
  end

endmodule
`default_nettype wire

// File: doc/dm_cache.md
# dm_cache

Direct-mapped, write-through, no-write-allocate cache between `multi_cycle_mips` and `async_mem`. It serves CPU read hits with zero wait cycles and fetches read misses from the 7 ns asynchronous memory through a fixed-length wait counter. It forwards every write to memory in the same cycle and keeps hit/miss statistics for the benches.

## Interface
- `LINES`, 16: number of one-word lines; power of two, ≥2; `IDX = log2(LINES)`.
- `MEM_LAT`, 4: cycles `mem_read` is held per fill; must satisfy `MEM_LAT × Tclk > 7 ns`; minimum 1.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; 0 = reset.
- `cpu_addr` in 32: byte address; bits [1:0] ignored.
- `cpu_wdata` in 32: write data.
- `cpu_read` in 1: read request.
- `cpu_write` in 1: write request; wins if both requests are high.
- `cpu_rdata` out 32: read data, valid only while `cpu_ready`=1, else 0.
- `cpu_ready` out 1: access completes this cycle.
- `mem_addr` out 32: memory byte address.
- `mem_wdata` out 32: memory write data.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable; memory samples it on the rising edge.
- `mem_rdata` in 32: memory read data.
- `hit_cnt` out 16: read hits, saturating.
- `miss_cnt` out 16: read misses, saturating.

## Operation
- Address split: index = `cpu_addr[IDX+1:2]`, tag = `cpu_addr[31:IDX+2]`. Per line: valid bit, tag, 32-bit data. The array is read combinationally.
- Hit = `valid[index]` && stored tag == tag.
- States: IDLE, FILL. Counter `lat_cnt` is `ceil(log2(MEM_LAT+1))` bits wide.
- IDLE, no request: all outputs 0.
- IDLE, write:
  - `mem_write`=1, `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `cpu_ready`=1.
  - On hit, the line data is updated at the same edge.
  - On miss, the line is untouched (no allocate).
  - State stays IDLE.
- IDLE, read hit: `cpu_ready`=1, `cpu_rdata`=line data, `hit_cnt`++ at the edge. State stays IDLE.
- IDLE, read miss: latch `cpu_addr` into `fill_addr`, `lat_cnt`←1, go to FILL. `cpu_ready`=0.
- FILL:
  - `mem_read`=1 and `mem_addr`=`fill_addr` in every FILL cycle.
  - While `lat_cnt` < `MEM_LAT`: `lat_cnt`++.
  - When `lat_cnt` == `MEM_LAT`: `cpu_ready`=1 and `cpu_rdata`=`mem_rdata`. At the edge, the line gets data=`mem_rdata`, tag, valid=1; `miss_cnt`++; state returns to IDLE.
- The CPU holds its request and address stable until it sees `cpu_ready`. Requests that change during FILL are ignored until return to IDLE.
- Counters saturate at 0xFFFF and do not wrap.

## Timing
- Reset (`reset`=0, asynchronous):
  - State IDLE, `lat_cnt`=0, all valid bits 0, `hit_cnt`=`miss_cnt`=0.
  - All outputs 0. Tag and data arrays are not cleared.
- Reset asserted mid-FILL aborts the fill: no line is written, no counter changes, `mem_read` drops immediately.
- Read hit latency: 0 wait cycles; `cpu_ready` in the request cycle.
- Write latency: 0 wait cycles; `mem_write` high for exactly one cycle per write.
- Read miss: request seen in cycle t; `mem_read` high in cycles t+1 … t+`MEM_LAT`; `cpu_ready` in cycle t+`MEM_LAT`.
- After any `cpu_ready`, the next request is evaluated in the following cycle. There is no dead cycle after a fill.
- A read of the same address right after its fill completion is a hit.
- Read and write in the same cycle: treated as a write only; no read data is returned.
- A write-hit to a line followed directly by a read returns the new data.

## Test plan
- Reset, then read 0x100 → `cpu_ready` low for 4 cycles, high in the 4th FILL cycle with memory word 0x100; `miss_cnt`=1. Re-read 0x100 → ready in the same cycle, same data; `hit_cnt`=1.
- Conflict: read 0x100, then 0x140 (same index, LINES=16), then 0x100 → three misses, `miss_cnt`=3, `hit_cnt`=0.
- Write 0xDEADBEEF to 0x100 after it is cached → one-cycle `mem_write`; memory word 0x40 = 0xDEADBEEF. Next read of 0x100 hits and returns 0xDEADBEEF.
- Write to uncached 0x200, then read 0x200 → write does not allocate; the read is a miss returning the written value.
- Pull `reset` low in the 2nd FILL cycle of a read to 0x180, then release and read 0x180 → `mem_read` drops at once; the re-read is a miss; counters are 0 then 1.
- Force `hit_cnt` near saturation with 65,540 repeated hits → `hit_cnt` stays at 0xFFFF.
